// File: rtl/image_writer.sv
// Streams RGB pixels into a byte-addressed frame buffer in bottom-up row order.
// Each pixel is written as B, G, R; every row is zero-padded to a 4-byte multiple.
module image_writer #(
    parameter int WIDTH  = 3,
    parameter int HEIGHT = 2,
    parameter int HDR    = 54,
    parameter int AW     = 16
) (
    input  logic          clka,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    Rin,
    input  logic [7:0]    Gin,
    input  logic [7:0]    Bin,
    input  logic          OKin,
    output logic          ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    localparam int ROW_RAW    = 3 * WIDTH;
    localparam int PAD_BYTES  = (4 - (ROW_RAW % 4)) % 4;
    localparam int ROW_BYTES  = ROW_RAW + PAD_BYTES;
    localparam int PAD_LAST_I = (PAD_BYTES > 0) ? PAD_BYTES - 1 : 0;

    localparam logic [AW-1:0] PTR0     = AW'(HDR + (HEIGHT - 1) * ROW_BYTES);
    localparam logic [AW-1:0] ROW_STEP = AW'(ROW_BYTES);
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [9:0]    COL_LAST = 10'(WIDTH - 1);
    localparam logic [9:0]    ROW_LAST = 10'(HEIGHT - 1);
    localparam logic [1:0]    PAD_LAST = 2'(PAD_LAST_I);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PIX = 3'd1,
        S_WR_B     = 3'd2,
        S_WR_G     = 3'd3,
        S_WR_R     = 3'd4,
        S_PAD      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t        state;
    logic [9:0]    row;
    logic [9:0]    col;
    logic [1:0]    pad_cnt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] row_base;
    logic [7:0]    r_lat;
    logic [7:0]    g_lat;
    logic [7:0]    b_lat;

    // Frame FSM; outputs are registered with the value the entered state decodes to.
    // ptr always holds the next byte address, and row_base the start of the current row.
    always_ff @(negedge clka or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            row       <= 10'd0;
            col       <= 10'd0;
            pad_cnt   <= 2'd0;
            ptr       <= '0;
            row_base  <= '0;
            r_lat     <= 8'd0;
            g_lat     <= 8'd0;
            b_lat     <= 8'd0;
            ready     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (OKin && (state == S_WR_B || state == S_WR_G ||
                         state == S_WR_R || state == S_PAD))
                ovf <= 1'b1;
            case (state)
                S_IDLE: begin
                    done   <= 1'b0;
                    mem_we <= 1'b0;
                    if (start) begin
                        state    <= S_WAIT_PIX;
                        ready    <= 1'b1;
                        busy     <= 1'b1;
                        row      <= 10'd0;
                        col      <= 10'd0;
                        ptr      <= PTR0;
                        row_base <= PTR0;
                        ovf      <= 1'b0;
                    end else begin
                        ready <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                S_WAIT_PIX: begin
                    if (OKin) begin
                        r_lat     <= Rin;
                        g_lat     <= Gin;
                        b_lat     <= Bin;
                        state     <= S_WR_B;
                        ready     <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= Bin;
                        ptr       <= ptr + ONE;
                    end else begin
                        ready  <= 1'b1;
                        mem_we <= 1'b0;
                    end
                end
                S_WR_B: begin
                    state     <= S_WR_G;
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= g_lat;
                    ptr       <= ptr + ONE;
                end
                S_WR_G: begin
                    state     <= S_WR_R;
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= r_lat;
                    ptr       <= ptr + ONE;
                end
                S_WR_R: begin
                    if (col != COL_LAST) begin
                        col    <= col + 10'd1;
                        state  <= S_WAIT_PIX;
                        ready  <= 1'b1;
                        mem_we <= 1'b0;
                    end else if (PAD_BYTES > 0) begin
                        state     <= S_PAD;
                        pad_cnt   <= 2'd0;
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= 8'd0;
                        ptr       <= ptr + ONE;
                    end else if (row != ROW_LAST) begin
                        row      <= row + 10'd1;
                        col      <= 10'd0;
                        row_base <= row_base - ROW_STEP;
                        ptr      <= row_base - ROW_STEP;
                        state    <= S_WAIT_PIX;
                        ready    <= 1'b1;
                        mem_we   <= 1'b0;
                    end else begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        mem_we <= 1'b0;
                    end
                end
                S_PAD: begin
                    if (pad_cnt != PAD_LAST) begin
                        pad_cnt   <= pad_cnt + 2'd1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= 8'd0;
                        ptr       <= ptr + ONE;
                    end else if (row != ROW_LAST) begin
                        row      <= row + 10'd1;
                        col      <= 10'd0;
                        row_base <= row_base - ROW_STEP;
                        ptr      <= row_base - ROW_STEP;
                        state    <= S_WAIT_PIX;
                        ready    <= 1'b1;
                        mem_we   <= 1'b0;
                    end else begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        mem_we <= 1'b0;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    ready  <= 1'b0;
                    mem_we <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    ready  <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_writer.sv
// Directed bench for image_writer: 3x2 frame layout, overflow, restarts and
// reset abort on one instance, and the unpadded 4-pixel-wide layout on a second.
module tb_image_writer;

    logic        clka;
    logic        reset;
    logic        start;
    logic        start4;
    logic [7:0]  Rin;
    logic [7:0]  Gin;
    logic [7:0]  Bin;
    logic        OKin;

    logic        ready,  mem_we,  busy,  done,  ovf;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        ready4, mem_we4, busy4, done4, ovf4;
    logic [15:0] mem_addr4;
    logic [7:0]  mem_wdata4;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    int          done_at[$];
    logic [15:0] wa4[$];
    logic [7:0]  wd4[$];
    int          done4_n = 0;

    logic [7:0] pr[8] = '{8'h11, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    logic [7:0] pg[8] = '{8'h22, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    logic [7:0] pb[8] = '{8'h33, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};

    // Expected 3x2 frame: row 0 at 66..77 (data + 3 pad), row 1 at 54..65.
    logic [15:0] exp_a[24] = '{
        16'd66, 16'd67, 16'd68, 16'd69, 16'd70, 16'd71, 16'd72, 16'd73, 16'd74, 16'd75, 16'd76, 16'd77,
        16'd54, 16'd55, 16'd56, 16'd57, 16'd58, 16'd59, 16'd60, 16'd61, 16'd62, 16'd63, 16'd64, 16'd65};
    logic [7:0] exp_d[24] = '{
        8'h33, 8'h22, 8'h11, 8'h61, 8'h51, 8'h41, 8'h62, 8'h52, 8'h42, 8'h00, 8'h00, 8'h00,
        8'h63, 8'h53, 8'h43, 8'h64, 8'h54, 8'h44, 8'h65, 8'h55, 8'h45, 8'h00, 8'h00, 8'h00};

    image_writer #(.WIDTH(3), .HEIGHT(2), .HDR(54), .AW(16)) dut (
        .clka(clka), .reset(reset), .start(start),
        .Rin(Rin), .Gin(Gin), .Bin(Bin), .OKin(OKin),
        .ready(ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .ovf(ovf)
    );

    image_writer #(.WIDTH(4), .HEIGHT(2), .HDR(54), .AW(16)) dut4 (
        .clka(clka), .reset(reset), .start(start4),
        .Rin(Rin), .Gin(Gin), .Bin(Bin), .OKin(OKin),
        .ready(ready4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .busy(busy4), .done(done4), .ovf(ovf4)
    );

    initial begin
        clka = 1'b1;
        forever #5 clka = ~clka;
    end

    // Write/done logger, sampled on the rising edge, half a cycle after the DUT updates.
    always @(posedge clka) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc_n);
        end
        if (done) done_at.push_back(wa.size());
        if (mem_we4) begin
            wa4.push_back(mem_addr4);
            wd4.push_back(mem_wdata4);
        end
        if (done4) done4_n++;
        cyc_n++;
    end

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); done_at.delete();
        wa4.delete(); wd4.delete(); done4_n = 0;
    endtask

    task automatic wait_ready(input bit four);
        int t = 0;
        while (((four ? ready4 : ready) !== 1'b1) && t < 30) begin
            @(posedge clka);
            t++;
        end
        if (t >= 30) begin
            errors++;
            $display("FAIL ready_timeout: ready never rose within 30 cycles");
        end
    endtask

    task automatic wait_idle(input bit four);
        int t = 0;
        while (((four ? busy4 : busy) !== 1'b0) && t < 60) begin
            @(posedge clka);
            t++;
        end
        if (t >= 60) begin
            errors++;
            $display("FAIL idle_timeout: busy still high after 60 cycles");
        end
    endtask

    // Drives a full 3x2 frame with OKin gaps; optionally pulses start mid-frame.
    task automatic run_frame(input bit pulse_start);
        start = 1'b1;
        @(posedge clka);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_ready(1'b0);
            if (pulse_start && k == 2) begin
                start = 1'b1;
                @(posedge clka);
                @(posedge clka);
                start = 1'b0;
            end
            if (k % 2 == 1) @(posedge clka);
            Rin = pr[k]; Gin = pg[k]; Bin = pb[k]; OKin = 1'b1;
            @(posedge clka);
            OKin = 1'b0;
        end
        wait_idle(1'b0);
        @(posedge clka);
    endtask

    task automatic check_frame_log(input string tag);
        checks++;
        if (wa.size() !== 24) begin
            errors++;
            $display("FAIL %s_write_count: got %0d expected 24", tag, wa.size());
        end
        for (int i = 0; i < 24 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL %s_write%0d: got addr %0d data %h expected addr %0d data %h",
                         tag, i, wa[i], wd[i], exp_a[i], exp_d[i]);
            end
        end
        checks++;
        if (done_at.size() !== 1 || done_at[0] !== 24) begin
            errors++;
            $display("FAIL %s_done_pulse: got %0d pulses (first after %0d writes) expected 1 after 24",
                     tag, done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clka);
        checks++;
        if ({ready, mem_we, busy, done, ovf} !== 5'b00000 || mem_addr !== 16'd0 || mem_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/we/busy/done/ovf %b addr %0d data %h expected 00000 0 00",
                     {ready, mem_we, busy, done, ovf}, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        @(posedge clka);
        @(posedge clka);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got busy %b ready %b expected 0 0", busy, ready);
        end
    endtask

    task automatic test_frame();
        clear_logs();
        start = 1'b1;
        @(posedge clka);
        start = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_wait: got ready %b busy %b expected 1 1", ready, busy);
        end
        for (int k = 0; k < 6; k++) begin
            wait_ready(1'b0);
            if (k % 2 == 1) @(posedge clka);
            Rin = pr[k]; Gin = pg[k]; Bin = pb[k]; OKin = 1'b1;
            @(posedge clka);
            OKin = 1'b0;
        end
        wait_idle(1'b0);
        @(posedge clka);
        check_frame_log("frame");
        checks++;
        if (wc.size() >= 3 && (wc[1] !== wc[0] + 1 || wc[2] !== wc[0] + 2)) begin
            errors++;
            $display("FAIL bgr_consecutive: got cycles %0d %0d %0d expected consecutive", wc[0], wc[1], wc[2]);
        end
        checks++;
        if (ovf !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL frame_end_state: got ovf %b busy %b we %b expected 0 0 0", ovf, busy, mem_we);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        clear_logs();
        start = 1'b1;
        @(posedge clka);
        start = 1'b0;
        OKin = 1'b1;
        while (busy === 1'b1 && n < 80) begin
            Rin = 8'hA0 + 8'(n); Gin = 8'h80 + 8'(n); Bin = 8'h60 + 8'(n);
            @(posedge clka);
            n++;
            if (n == 2) begin
                checks++;
                if (ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set: got %b expected 1", ovf);
                end
            end
        end
        OKin = 1'b0;
        @(posedge clka);
        checks++;
        if (wa.size() !== 24) begin
            errors++;
            $display("FAIL ovf_write_count: got %0d expected 24", wa.size());
        end
        if (wa.size() >= 4) begin
            checks++;
            if (wd[0] !== 8'h60 || wd[1] !== 8'h80 || wd[2] !== 8'hA0 || wd[3] !== 8'h64 || wa[0] !== 16'd66) begin
                errors++;
                $display("FAIL ovf_sampled_data: got %h %h %h %h at %0d expected 60 80 a0 64 at 66",
                         wd[0], wd[1], wd[2], wd[3], wa[0]);
            end
            checks++;
            if (wc[3] - wc[0] !== 4) begin
                errors++;
                $display("FAIL accept_spacing: got %0d cycles expected 4", wc[3] - wc[0]);
            end
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf);
        end
    endtask

    task automatic test_start_in_wait();
        clear_logs();
        run_frame(1'b1);
        check_frame_log("restart_ignored");
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared_on_start: got %b expected 0", ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        clear_logs();
        start = 1'b1;
        @(posedge clka);
        start = 1'b0;
        Rin = pr[0]; Gin = pg[0]; Bin = pb[0]; OKin = 1'b1;
        @(posedge clka);
        OKin = 1'b0;
        @(posedge clka);
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 8'h22 || mem_addr !== 16'd67) begin
            errors++;
            $display("FAIL in_wr_g: got we %b addr %0d data %h expected 1 67 22", mem_we, mem_addr, mem_wdata);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: got we %b busy %b ready %b expected 0 0 0", mem_we, busy, ready);
        end
        n = wa.size();
        @(posedge clka);
        reset = 1'b0;
        repeat (3) @(posedge clka);
        checks++;
        if (wa.size() !== n) begin
            errors++;
            $display("FAIL writes_after_abort: got %0d writes expected %0d", wa.size(), n);
        end
        start = 1'b1;
        @(posedge clka);
        start = 1'b0;
        Rin = pr[3]; Gin = pg[3]; Bin = pb[3]; OKin = 1'b1;
        @(posedge clka);
        OKin = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'd66 || mem_wdata !== 8'h63) begin
            errors++;
            $display("FAIL restart_addr: got we %b addr %0d data %h expected 1 66 63", mem_we, mem_addr, mem_wdata);
        end
        reset = 1'b1;
        @(posedge clka);
        reset = 1'b0;
        @(posedge clka);
    endtask

    task automatic test_width4();
        logic [15:0] ea;
        logic [7:0]  ed;
        clear_logs();
        start4 = 1'b1;
        @(posedge clka);
        start4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_ready(1'b1);
            Rin = pr[k]; Gin = pg[k]; Bin = pb[k]; OKin = 1'b1;
            @(posedge clka);
            OKin = 1'b0;
        end
        wait_idle(1'b1);
        @(posedge clka);
        checks++;
        if (wa4.size() !== 24 || done4_n !== 1) begin
            errors++;
            $display("FAIL w4_counts: got %0d writes %0d done expected 24 1", wa4.size(), done4_n);
        end
        for (int i = 0; i < 24 && i < wa4.size(); i++) begin
            ea = (i < 12) ? 16'(66 + i) : 16'(54 + i - 12);
            ed = (i % 3 == 0) ? pb[i / 3] : ((i % 3 == 1) ? pg[i / 3] : pr[i / 3]);
            checks++;
            if (wa4[i] !== ea || wd4[i] !== ed) begin
                errors++;
                $display("FAIL w4_write%0d: got addr %0d data %h expected addr %0d data %h",
                         i, wa4[i], wd4[i], ea, ed);
            end
        end
        checks++;
        if (wa.size() !== 0) begin
            errors++;
            $display("FAIL w3_idle_during_w4: got %0d writes expected 0", wa.size());
        end
    endtask

    initial begin
        start = 1'b0; start4 = 1'b0; OKin = 1'b0;
        Rin = 8'd0; Gin = 8'd0; Bin = 8'd0;
        reset = 1'b1;
        test_reset();
        test_frame();
        test_overflow();
        test_start_in_wait();
        test_reset_mid_frame();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
